el2_lsu_fault_pipe: RTL and testbench

//  Downstream of LSU address check: carries per-access fault results (misaligned/access, mscause, addr)

---
 rtl/el2_pkg.sv | 39 +++
 rtl/el2_lsu_fault_stage.sv | 37 +++
 rtl/el2_lsu_fault_pipe.sv | 153 +++++++++++++++
 tb/tb_el2_lsu_fault_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/el2_pkg.sv
// Shared types for the LSU fault pipeline: fault packet, exception encoding, capture FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package el2_pkg;

  localparam int EL2_ADDR_W    = 32;
  localparam int EL2_MSCAUSE_W = 4;

  localparam logic EXC_MISALIGNED = 1'b0;
  localparam logic EXC_ACCESS     = 1'b1;

  typedef struct packed {
    logic                     exc_type;
    logic                     store;
    logic [EL2_MSCAUSE_W-1:0] mscause;
    logic [EL2_ADDR_W-1:0]    addr;
  } el2_lsu_fault_pkt_t;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_HELD = 1'b1
  } el2_cap_state_t;

  // Misaligned takes priority when both fault sources fire on the same access.
  function automatic el2_lsu_fault_pkt_t make_fault_pkt(
    input logic                     misaligned,
    input logic                     store,
    input logic [EL2_MSCAUSE_W-1:0] mscause,
    input logic [EL2_ADDR_W-1:0]    addr
  );
    el2_lsu_fault_pkt_t p;
    p.exc_type = misaligned ? EXC_MISALIGNED : EXC_ACCESS;
    p.store    = store;
    p.mscause  = mscause;
    p.addr     = addr;
    return p;
  endfunction

endpackage

// File: rtl/el2_lsu_fault_stage.sv
// One valid+packet pipeline register with stall hold and flush.
// Latency: 1 cycle from vld_in/pkt_in to vld_out/pkt_out when not stalled.
// Backpressure: stall holds contents; flush clears valid and beats both stall and advance.
// Ports: clk, rst_l (async active-low), stall, flush, vld_in, pkt_in -> vld_out, pkt_out.
module el2_lsu_fault_stage
  import el2_pkg::*;
(
  input  logic               clk,
  input  logic               rst_l,
  input  logic               stall,
  input  logic               flush,
  input  logic               vld_in,
  input  el2_lsu_fault_pkt_t pkt_in,
  output logic               vld_out,
  output el2_lsu_fault_pkt_t pkt_out
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_out <= 1'b0;
    end else if (flush) begin
      vld_out <= 1'b0;
    end else if (!stall) begin
      vld_out <= vld_in;
    end
  end

  // Payload only moves with a valid entry so fields stay stable while idle.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pkt_out <= '0;
    end else if (!stall && vld_in) begin
      pkt_out <= pkt_in;
    end
  end

endmodule

// File: rtl/el2_lsu_fault_pipe.sv
// Carries LSU fault results D->M->R, presents an R-stage record, captures first unacked fault, counts faults.
// Latency: fault in D at cycle N -> err_valid_r in N+2; capture/count visible in N+3.
// Backpressure: stall_m holds M and R; flush_m/flush_r kill entries; unacked capture sets cap_overflow.
// Ports: clk, rst_l, lsu_*_d / *_fault_d / exc_mscause_d / start_addr_d, stall_m, flush_m, flush_r,
//        tlu_ack, cnt_clr -> err_*_r, cap_valid, cap_pkt, cap_overflow, fault_cnt.
module el2_lsu_fault_pipe
  import el2_pkg::*;
#(
  parameter int ADDR_W    = EL2_ADDR_W,
  parameter int MSCAUSE_W = EL2_MSCAUSE_W,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 lsu_valid_d,
  input  logic                 lsu_store_d,
  input  logic                 lsu_dma_d,
  input  logic                 misaligned_fault_d,
  input  logic                 access_fault_d,
  input  logic [MSCAUSE_W-1:0] exc_mscause_d,
  input  logic [ADDR_W-1:0]    start_addr_d,
  input  logic                 stall_m,
  input  logic                 flush_m,
  input  logic                 flush_r,
  input  logic                 tlu_ack,
  input  logic                 cnt_clr,
  output logic                 err_valid_r,
  output logic                 err_exc_type_r,
  output logic                 err_store_r,
  output logic [MSCAUSE_W-1:0] err_mscause_r,
  output logic [ADDR_W-1:0]    err_addr_r,
  output logic                 cap_valid,
  output el2_lsu_fault_pkt_t   cap_pkt,
  output logic                 cap_overflow,
  output logic [CNT_W-1:0]     fault_cnt
);

  // The packet struct has fixed field widths; the width parameters must agree with it.
  if (ADDR_W != EL2_ADDR_W || MSCAUSE_W != EL2_MSCAUSE_W) begin : g_width_check
    $error("el2_lsu_fault_pipe: ADDR_W/MSCAUSE_W must match el2_pkg packet widths");
  end

  // D stage: DMA accesses never fault.
  logic               d_vld;
  el2_lsu_fault_pkt_t d_pkt;

  assign d_vld = lsu_valid_d & ~lsu_dma_d & (misaligned_fault_d | access_fault_d);
  assign d_pkt = make_fault_pkt(misaligned_fault_d, lsu_store_d, exc_mscause_d, start_addr_d);

  logic               m_vld;
  el2_lsu_fault_pkt_t m_pkt;
  logic               r_vld;
  el2_lsu_fault_pkt_t r_pkt;

  el2_lsu_fault_stage u_stage_m (
    .clk     (clk),
    .rst_l   (rst_l),
    .stall   (stall_m),
    .flush   (flush_m),
    .vld_in  (d_vld),
    .pkt_in  (d_pkt),
    .vld_out (m_vld),
    .pkt_out (m_pkt)
  );

  // An entry flushed in M must not slip into R on the same edge.
  el2_lsu_fault_stage u_stage_r (
    .clk     (clk),
    .rst_l   (rst_l),
    .stall   (stall_m),
    .flush   (flush_r),
    .vld_in  (m_vld & ~flush_m),
    .pkt_in  (m_pkt),
    .vld_out (r_vld),
    .pkt_out (r_pkt)
  );

  assign err_valid_r    = r_vld;
  assign err_exc_type_r = r_pkt.exc_type;
  assign err_store_r    = r_pkt.store;
  assign err_mscause_r  = r_pkt.mscause;
  assign err_addr_r     = r_pkt.addr;

  // Record fires on the last cycle an entry sits in R, so a stalled entry counts once.
  logic rec;
  assign rec = r_vld & ~flush_r & ~stall_m;

  // Capture FSM
  el2_cap_state_t cap_state, cap_state_nxt;
  logic           cap_load;
  logic           ovf_nxt;

  always_comb begin
    cap_state_nxt = cap_state;
    cap_load      = 1'b0;
    ovf_nxt       = cap_overflow;
    case (cap_state)
      CAP_IDLE: begin
        if (rec) begin
          cap_load      = 1'b1;
          cap_state_nxt = CAP_HELD;
        end
      end
      CAP_HELD: begin
        if (tlu_ack) begin
          ovf_nxt = 1'b0;
          if (rec) begin
            cap_load = 1'b1;
          end else begin
            cap_state_nxt = CAP_IDLE;
          end
        end else if (rec) begin
          ovf_nxt = 1'b1;
        end
      end
      default: begin
        cap_state_nxt = CAP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cap_state    <= CAP_IDLE;
      cap_overflow <= 1'b0;
    end else begin
      cap_state    <= cap_state_nxt;
      cap_overflow <= ovf_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cap_pkt <= '0;
    end else if (cap_load) begin
      cap_pkt <= r_pkt;
    end
  end

  assign cap_valid = (cap_state == CAP_HELD);

  // Saturating fault counter; clear wins over a concurrent record.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fault_cnt <= '0;
    end else if (cnt_clr) begin
      fault_cnt <= '0;
    end else if (rec && (fault_cnt != {CNT_W{1'b1}})) begin
      fault_cnt <= fault_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_el2_lsu_fault_pipe.sv
module tb_el2_lsu_fault_pipe;
  import el2_pkg::*;

  logic        clk;
  logic        rst_l;
  logic        lsu_valid_d, lsu_store_d, lsu_dma_d;
  logic        misaligned_fault_d, access_fault_d;
  logic [3:0]  exc_mscause_d;
  logic [31:0] start_addr_d;
  logic        stall_m, flush_m, flush_r, tlu_ack, cnt_clr;

  logic               err_valid_r, err_exc_type_r, err_store_r;
  logic [3:0]         err_mscause_r;
  logic [31:0]        err_addr_r;
  logic               cap_valid, cap_overflow;
  el2_lsu_fault_pkt_t cap_pkt;
  logic [15:0]        fault_cnt;

  logic               s_err_valid_r, s_err_exc_type_r, s_err_store_r;
  logic [3:0]         s_err_mscause_r;
  logic [31:0]        s_err_addr_r;
  logic               s_cap_valid, s_cap_overflow;
  el2_lsu_fault_pkt_t s_cap_pkt;
  logic [1:0]         s_fault_cnt;

  int n_cmp = 0;
  int n_err = 0;

  el2_lsu_fault_pipe #(.ADDR_W(32), .MSCAUSE_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_l(rst_l),
    .lsu_valid_d(lsu_valid_d), .lsu_store_d(lsu_store_d), .lsu_dma_d(lsu_dma_d),
    .misaligned_fault_d(misaligned_fault_d), .access_fault_d(access_fault_d),
    .exc_mscause_d(exc_mscause_d), .start_addr_d(start_addr_d),
    .stall_m(stall_m), .flush_m(flush_m), .flush_r(flush_r),
    .tlu_ack(tlu_ack), .cnt_clr(cnt_clr),
    .err_valid_r(err_valid_r), .err_exc_type_r(err_exc_type_r), .err_store_r(err_store_r),
    .err_mscause_r(err_mscause_r), .err_addr_r(err_addr_r),
    .cap_valid(cap_valid), .cap_pkt(cap_pkt), .cap_overflow(cap_overflow),
    .fault_cnt(fault_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  el2_lsu_fault_pipe #(.ADDR_W(32), .MSCAUSE_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_l(rst_l),
    .lsu_valid_d(lsu_valid_d), .lsu_store_d(lsu_store_d), .lsu_dma_d(lsu_dma_d),
    .misaligned_fault_d(misaligned_fault_d), .access_fault_d(access_fault_d),
    .exc_mscause_d(exc_mscause_d), .start_addr_d(start_addr_d),
    .stall_m(stall_m), .flush_m(flush_m), .flush_r(flush_r),
    .tlu_ack(tlu_ack), .cnt_clr(cnt_clr),
    .err_valid_r(s_err_valid_r), .err_exc_type_r(s_err_exc_type_r), .err_store_r(s_err_store_r),
    .err_mscause_r(s_err_mscause_r), .err_addr_r(s_err_addr_r),
    .cap_valid(s_cap_valid), .cap_pkt(s_cap_pkt), .cap_overflow(s_cap_overflow),
    .fault_cnt(s_fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fault(input logic mis, input logic acc, input logic st,
                             input logic [3:0] msc, input logic [31:0] addr);
    lsu_valid_d        = 1'b1;
    lsu_store_d        = st;
    lsu_dma_d          = 1'b0;
    misaligned_fault_d = mis;
    access_fault_d     = acc;
    exc_mscause_d      = msc;
    start_addr_d       = addr;
  endtask

  task automatic drive_idle();
    lsu_valid_d        = 1'b0;
    lsu_store_d        = 1'b0;
    lsu_dma_d          = 1'b0;
    misaligned_fault_d = 1'b0;
    access_fault_d     = 1'b0;
    exc_mscause_d      = 4'h0;
    start_addr_d       = 32'h0;
  endtask

  initial begin
    rst_l = 1'b0;
    drive_idle();
    stall_m = 0; flush_m = 0; flush_r = 0; tlu_ack = 0; cnt_clr = 0;
    #12;
    // Reset state
    chk("rst_err_valid", err_valid_r, 0);
    chk("rst_err_addr", err_addr_r, 0);
    chk("rst_cap_valid", cap_valid, 0);
    chk("rst_cap_pkt", cap_pkt, 0);
    chk("rst_cnt", fault_cnt, 0);
    chk("rst_sat_all", {s_err_valid_r, s_err_exc_type_r, s_err_store_r, s_err_mscause_r,
                        s_cap_valid, s_cap_overflow, s_fault_cnt}, 0);
    chk("rst_sat_addr_pkt", {s_err_addr_r, s_cap_pkt}, 0);
    rst_l = 1'b1;
    tick(); tick();

    // 1: load, misaligned+access, mscause 1 -> exc_type 0 at R, capture one cycle later
    drive_fault(1, 1, 0, 4'h1, 32'h2000_0002);
    tick(); drive_idle();
    chk("t1_m_not_r", err_valid_r, 0);
    tick();
    chk("t1_err_valid", err_valid_r, 1);
    chk("t1_exc_type", err_exc_type_r, 0);
    chk("t1_store", err_store_r, 0);
    chk("t1_mscause", err_mscause_r, 4'h1);
    chk("t1_addr", err_addr_r, 32'h2000_0002);
    chk("t1_cap_not_yet", cap_valid, 0);
    tick();
    chk("t1_err_gone", err_valid_r, 0);
    chk("t1_cap_valid", cap_valid, 1);
    chk("t1_cap_addr", cap_pkt.addr, 32'h2000_0002);
    chk("t1_cnt", fault_cnt, 1);
    tlu_ack = 1; tick(); tlu_ack = 0;
    chk("t1_ack_idle", cap_valid, 0);
    tlu_ack = 1; tick(); tlu_ack = 0;
    chk("t1_ack_in_idle_ignored", cap_valid, 0);

    // 2: DMA access fault is dropped
    drive_fault(0, 1, 1, 4'h3, 32'h0000_1000);
    lsu_dma_d = 1'b1;
    tick(); drive_idle(); tick();
    chk("t2_dma_no_err", err_valid_r, 0);
    tick();
    chk("t2_dma_no_cap", cap_valid, 0);
    chk("t2_dma_cnt", fault_cnt, 1);

    // 3a: fault flushed while in M never reaches R
    drive_fault(0, 1, 0, 4'h2, 32'h0000_0040);
    tick(); drive_idle();
    flush_m = 1; tick(); flush_m = 0;
    chk("t3_flush_m_r", err_valid_r, 0);
    tick();
    chk("t3_flush_m_cnt", fault_cnt, 1);
    chk("t3_flush_m_cap", cap_valid, 0);

    // 3b: R fault held 3 cycles by stall_m counts once
    drive_fault(0, 1, 1, 4'h5, 32'h0000_0080);
    tick(); drive_idle(); tick();
    chk("t3_stall_r_valid", err_valid_r, 1);
    chk("t3_access_type", err_exc_type_r, 1);
    chk("t3_store", err_store_r, 1);
    stall_m = 1; tick(); tick(); tick();
    chk("t3_stall_hold", err_valid_r, 1);
    chk("t3_stall_hold_addr", err_addr_r, 32'h0000_0080);
    chk("t3_stall_no_cnt", fault_cnt, 1);
    stall_m = 0; tick();
    chk("t3_stall_cnt_once", fault_cnt, 2);
    chk("t3_stall_cap", cap_valid, 1);
    tick();
    chk("t3_stall_cnt_stays", fault_cnt, 2);
    tlu_ack = 1; tick(); tlu_ack = 0;

    // 4: two unacked faults -> keep first, overflow; CNT_W=2 saturates after 4 faults
    drive_fault(0, 1, 0, 4'h1, 32'h0000_0010);
    tick();
    drive_fault(0, 1, 0, 4'h2, 32'h0000_0020);
    tick(); drive_idle();
    tick();
    chk("t4_first_cap", cap_pkt.addr, 32'h0000_0010);
    chk("t4_no_ovf_yet", cap_overflow, 0);
    tick();
    chk("t4_cap_addr", cap_pkt.addr, 32'h0000_0010);
    chk("t4_cap_mscause", cap_pkt.mscause, 4'h1);
    chk("t4_overflow", cap_overflow, 1);
    chk("t4_cnt", fault_cnt, 4);
    chk("t4_sat_cnt", s_fault_cnt, 2'd3);
    tlu_ack = 1; tick(); tlu_ack = 0;
    chk("t4_ack_idle", cap_valid, 0);
    chk("t4_ack_ovf_clr", cap_overflow, 0);
    // ack coincident with record of 0x30 reloads and stays HELD
    drive_fault(0, 1, 0, 4'h4, 32'h0000_0028);
    tick();
    drive_fault(1, 0, 1, 4'h6, 32'h0000_0030);
    tick(); drive_idle(); tick();
    chk("t4_held_28", cap_pkt.addr, 32'h0000_0028);
    tlu_ack = 1; tick(); tlu_ack = 0;
    chk("t4_reload_held", cap_valid, 1);
    chk("t4_reload_addr", cap_pkt.addr, 32'h0000_0030);
    chk("t4_reload_type", cap_pkt.exc_type, 0);
    chk("t4_reload_ovf", cap_overflow, 0);
    chk("t4_sat_cnt_hold", s_fault_cnt, 2'd3);
    tlu_ack = 1; tick(); tlu_ack = 0;

    // 5: cnt_clr beats a concurrent record
    drive_fault(0, 1, 0, 4'h7, 32'h0000_0050);
    tick(); drive_idle(); tick();
    chk("t5_pre_cnt", fault_cnt, 6);
    cnt_clr = 1; tick(); cnt_clr = 0;
    chk("t5_clr_cnt", fault_cnt, 0);
    chk("t5_clr_sat_cnt", s_fault_cnt, 0);
    chk("t5_cap_still", cap_valid, 1);
    tlu_ack = 1; tick(); tlu_ack = 0;

    // 6: async reset with M and R valid discards everything
    drive_fault(0, 1, 0, 4'h8, 32'h0000_0060);
    tick();
    drive_fault(0, 1, 0, 4'h9, 32'h0000_0070);
    tick(); drive_idle();
    chk("t6_r_valid_before", err_valid_r, 1);
    #2 rst_l = 1'b0;
    #1;
    chk("t6_rst_err_valid", err_valid_r, 0);
    chk("t6_rst_err_addr", err_addr_r, 0);
    chk("t6_rst_cap_valid", cap_valid, 0);
    chk("t6_rst_cnt", fault_cnt, 0);
    tick();
    rst_l = 1'b1;
    tick(); tick(); tick();
    chk("t6_post_err_valid", err_valid_r, 0);
    chk("t6_post_cap", cap_valid, 0);
    chk("t6_post_cnt", fault_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
